// File: rtl/id_operand_stage_pkg.sv
// Shared encodings and widths for the ID-stage operand path: forward selects,
// branch conditions, FSM states and the operand forward-mux helper.
package id_operand_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_ID  = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BGZ  = 2'b11;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_LSTALL = 1'b1;

  // MEM/WB data, EX/MEM value and the EX ALU output are selected by the
  // forwarding unit; FWD_RF falls back to the register file (with bypass).
  function automatic data_t fwd_sel(input logic [1:0] sel, input data_t rf,
                                    input data_t wb, input data_t exmem,
                                    input data_t idex);
    case (sel)
      FWD_MEM: return wb;
      FWD_EX:  return exmem;
      FWD_ID:  return idex;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bus between decode/forwarding logic and the ID operand stage.
// master drives decode inputs; slave is the operand stage itself.
interface id_operand_stage_if;
  import id_operand_stage_pkg::*;

  logic       instr_valid;
  reg_idx_t   rs, rt, rd;
  logic       regwrite_in;
  logic       memread_in;
  data_t      imm_in;
  logic [1:0] br_cond;
  logic [1:0] IDforwardA, IDforwardB;
  data_t      ex_result;
  data_t      mem_result;
  logic       wb_regwrite;
  reg_idx_t   wb_rd;
  data_t      wb_data;
  logic       flush;

  logic       stall;
  data_t      opA_q, opB_q, imm_q;
  reg_idx_t   rd_q;
  logic       regwrite_q, memread_q, valid_q;
  logic       branch_taken;
  data_t      stall_count;

  modport master (
    output instr_valid, rs, rt, rd, regwrite_in, memread_in, imm_in, br_cond,
           IDforwardA, IDforwardB, ex_result, mem_result, wb_regwrite, wb_rd,
           wb_data, flush,
    input  stall, opA_q, opB_q, imm_q, rd_q, regwrite_q, memread_q, valid_q,
           branch_taken, stall_count
  );

  modport slave (
    input  instr_valid, rs, rt, rd, regwrite_in, memread_in, imm_in, br_cond,
           IDforwardA, IDforwardB, ex_result, mem_result, wb_regwrite, wb_rd,
           wb_data, flush,
    output stall, opA_q, opB_q, imm_q, rd_q, regwrite_q, memread_q, valid_q,
           branch_taken, stall_count
  );

endinterface

// File: rtl/id_operand_stage_regfile.sv
// 4x16 register file: two read ports, one write port, write-through bypass so
// a read of the register being written this cycle returns the new data.
module id_regfile
  import id_operand_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  reg_idx_t raddr_a_i,
  input  reg_idx_t raddr_b_i,
  output data_t    rdata_a_o,
  output data_t    rdata_b_o,
  input  logic     we_i,
  input  reg_idx_t waddr_i,
  input  data_t    wdata_i
);

  data_t regs_q [NUM_REGS];

  // NOTE: this array is tiny and architecturally must read 0 after reset, so it
  // is reset like flops; large RAMs would be left unreset to map onto macros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand path: regfile, forward muxes, load-use stall FSM and ID/EX
// register. Optional ID branch resolution enabled by ID_BRANCH_RESOLVE_EN.
module id_operand_stage
  import id_operand_stage_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  id_operand_stage_if.slave bus
);

  data_t      rf_a, rf_b;
  data_t      opa, opb;
  logic       hazard;
  logic       stall;
  logic       bubble;
  logic [0:0] state_q, state_d;

  data_t      opa_q, opb_q, imm_q;
  reg_idx_t   rd_q;
  logic       regwrite_q, memread_q, valid_q;
  data_t      stall_cnt_q;

  id_regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .raddr_a_i (bus.rs),
    .raddr_b_i (bus.rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (bus.wb_regwrite),
    .waddr_i   (bus.wb_rd),
    .wdata_i   (bus.wb_data)
  );

  assign opa = fwd_sel(bus.IDforwardA, rf_a, bus.wb_data, bus.mem_result, bus.ex_result);
  assign opb = fwd_sel(bus.IDforwardB, rf_b, bus.wb_data, bus.mem_result, bus.ex_result);

  // Branches share this term: any instruction whose sources hit a load in ID/EX.
  assign hazard = memread_q & regwrite_q & valid_q & bus.instr_valid &
                  ((rd_q == bus.rs) | (rd_q == bus.rt));

  assign stall = (state_q == ST_RUN) & hazard & ~bus.flush;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d = ST_RUN;
    bubble  = 1'b0;
    if (bus.flush) begin
      bubble = 1'b1;
    end else if (stall) begin
      state_d = ST_LSTALL;
      bubble  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      opa_q       <= '0;
      opb_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa;
      opb_q      <= opb;
      imm_q      <= bus.imm_in;
      rd_q       <= bus.rd;
      valid_q    <= bus.instr_valid & ~bubble;
      regwrite_q <= bus.regwrite_in & bus.instr_valid & ~bubble;
      memread_q  <= bus.memread_in & bus.instr_valid & ~bubble;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

`ifdef ID_BRANCH_RESOLVE_EN
  logic br_cond_met;

  always_comb begin
    br_cond_met = 1'b0;
    case (bus.br_cond)
      BR_BEQ:  br_cond_met = (opa == opb);
      BR_BNE:  br_cond_met = (opa != opb);
      BR_BGZ:  br_cond_met = ~opa[DATA_W-1] & (opa != '0);
      default: br_cond_met = 1'b0;
    endcase
  end

  assign bus.branch_taken = bus.instr_valid & br_cond_met & ~stall;
`else
  assign bus.branch_taken = 1'b0;
`endif

  assign bus.stall       = stall;
  assign bus.opA_q       = opa_q;
  assign bus.opB_q       = opb_q;
  assign bus.imm_q       = imm_q;
  assign bus.rd_q        = rd_q;
  assign bus.regwrite_q  = regwrite_q;
  assign bus.memread_q   = memread_q;
  assign bus.valid_q     = valid_q;
  assign bus.stall_count = stall_cnt_q;

endmodule
